vip_amba_apb_master_bridge: RTL and testbench



---
 rtl/vip_amba_apb_pkg.sv | 17 +
 rtl/vip_amba_apb_timeout_counter.sv | 28 ++
 rtl/vip_amba_apb_master_bridge.sv | 172 +++++++++++++++++
 tb/tb_vip_amba_apb_master_bridge.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vip_amba_apb_pkg.sv
// Shared types and constants for the APB4 master bridge and its timeout counter.
package vip_amba_apb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StDone
  } apb_mst_state_e;

  // Encoding of from_cpu_rd_wr
  localparam logic RdWrRead  = 1'b0;
  localparam logic RdWrWrite = 1'b1;

  localparam logic [2:0] PprotDefault = 3'b000;

endpackage

// File: rtl/vip_amba_apb_timeout_counter.sv
// Counts consecutive PREADY-low ACCESS cycles; expired marks the last allowed wait cycle.
module vip_amba_apb_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic PCLK,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge PCLK) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (count_en && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // High during the TIMEOUT_CYCLES-th low cycle, so the abort lands on that cycle's edge
  assign expired = (cnt_q == CntLast);

endmodule

// File: rtl/vip_amba_apb_master_bridge.sv
// APB4 master bridge: one CPU request at a time through SETUP/ACCESS, all outputs registered.
// Optional ACCESS timeout abort is built when VIP_AMBA_APB_TIMEOUT_EN is defined.
module vip_amba_apb_master_bridge
  import vip_amba_apb_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DATA_STROBE    = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [2:0]  PPROT_VAL      = PprotDefault
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     from_cpu_resetn,
  input  logic                     from_cpu_valid_txn,
  input  logic                     from_cpu_rd_wr,
  input  logic [ADDRESS_WIDTH-1:0] from_cpu_address,
  input  logic [DATA_STROBE-1:0]   from_cpu_wr_STRB,
  input  logic [DATA_WIDTH-1:0]    from_cpu_wr_WDATA,
  input  logic                     from_cpu_slave_sel,
  output logic                     apb_ready_for_txn,
  output logic [DATA_WIDTH-1:0]    to_cpu_RDATA,
  output logic                     to_cpu_RDATA_valid_WDATA_done,
  output logic                     to_cpu_txn_err,
  output logic                     to_cpu_txn_timeout,
  input  logic                     PREADY,
  input  logic [DATA_WIDTH-1:0]    PRDATA,
  input  logic                     PSLVERR,
  output logic [ADDRESS_WIDTH-1:0] PADDR,
  output logic [2:0]               PPROT,
  output logic                     PSELx,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [DATA_WIDTH-1:0]    PWDATA,
  output logic [DATA_STROBE-1:0]   PSTRB
);

  apb_mst_state_e           state_q;
  logic                     ready_q;
  logic                     psel_q;
  logic                     penable_q;
  logic                     pwrite_q;
  logic [ADDRESS_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0]    pwdata_q;
  logic [DATA_STROBE-1:0]   pstrb_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic                     done_q;
  logic                     err_q;
  logic                     timeout_q;
  logic                     rst;
  logic                     abort;
  logic                     xfer_ok;

  // CPU soft reset folds into the bus reset
  assign rst = PRESET | ~from_cpu_resetn;

  // Completion handshake: only here are PSLVERR and PRDATA meaningful
  assign xfer_ok = psel_q & penable_q & PREADY;

`ifdef VIP_AMBA_APB_TIMEOUT_EN
  logic to_clear;
  logic to_count_en;
  logic to_expired;

  assign to_clear    = (state_q == StSetup);
  assign to_count_en = (state_q == StAccess) && !PREADY;

  vip_amba_apb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_counter (
    .PCLK    (PCLK),
    .rst     (rst),
    .clear   (to_clear),
    .count_en(to_count_en),
    .expired (to_expired)
  );

  assign abort              = to_count_en && to_expired;
  assign to_cpu_txn_timeout = timeout_q;
`else
  logic unused_timeout_cfg;

  assign abort              = 1'b0;
  assign to_cpu_txn_timeout = 1'b0;
  assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, timeout_q};
`endif

  always_ff @(posedge PCLK) begin
    if (rst) begin
      state_q   <= StIdle;
      ready_q   <= 1'b1;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (from_cpu_valid_txn) begin
            ready_q <= 1'b0;
            if (from_cpu_slave_sel) begin
              state_q  <= StSetup;
              psel_q   <= 1'b1;
              pwrite_q <= from_cpu_rd_wr;
              paddr_q  <= from_cpu_address;
              pwdata_q <= (from_cpu_rd_wr == RdWrWrite) ? from_cpu_wr_WDATA : '0;
              pstrb_q  <= (from_cpu_rd_wr == RdWrWrite) ? from_cpu_wr_STRB : '0;
            end else begin
              // Decode error: complete without touching the bus
              state_q <= StDone;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end
        StSetup: begin
          state_q   <= StAccess;
          penable_q <= 1'b1;
        end
        StAccess: begin
          if (xfer_ok) begin
            state_q   <= StDone;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= PSLVERR;
            if ((pwrite_q == RdWrRead) && !PSLVERR) begin
              rdata_q <= PRDATA;
            end
          end else if (abort) begin
            state_q   <= StDone;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign apb_ready_for_txn             = ready_q;
  assign to_cpu_RDATA                  = rdata_q;
  assign to_cpu_RDATA_valid_WDATA_done = done_q;
  assign to_cpu_txn_err                = err_q;
  assign PADDR                         = paddr_q;
  assign PPROT                         = PPROT_VAL;
  assign PSELx                         = psel_q;
  assign PENABLE                       = penable_q;
  assign PWRITE                        = pwrite_q;
  assign PWDATA                        = pwdata_q;
  assign PSTRB                         = pstrb_q;

endmodule

// File: tb/tb_vip_amba_apb_master_bridge.sv
// Table-driven bench for the APB master bridge with a completion scoreboard.
module tb_vip_amba_apb_master_bridge;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 16;

  typedef struct {
    logic          rd_wr;
    logic [AW-1:0] addr;
    logic [SW-1:0] strb;
    logic [DW-1:0] wdata;
    logic          sel;
    int            waits;
    logic [DW-1:0] prdata;
    logic          pslverr;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } txn_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          timeout;
  } sb_t;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          from_cpu_resetn;
  logic          from_cpu_valid_txn;
  logic          from_cpu_rd_wr;
  logic [AW-1:0] from_cpu_address;
  logic [SW-1:0] from_cpu_wr_STRB;
  logic [DW-1:0] from_cpu_wr_WDATA;
  logic          from_cpu_slave_sel;
  logic          apb_ready_for_txn;
  logic [DW-1:0] to_cpu_RDATA;
  logic          to_cpu_RDATA_valid_WDATA_done;
  logic          to_cpu_txn_err;
  logic          to_cpu_txn_timeout;
  logic          PREADY;
  logic [DW-1:0] PRDATA;
  logic          PSLVERR;
  logic [AW-1:0] PADDR;
  logic [2:0]    PPROT;
  logic          PSELx;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTRB;

  int  n_checks = 0;
  int  n_fail   = 0;
  sb_t sb_q[$];
  txn_t vecs[7];

  always #5 PCLK = ~PCLK;

  vip_amba_apb_master_bridge #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .DATA_STROBE   (SW),
    .TIMEOUT_CYCLES(TO),
    .PPROT_VAL     (3'b000)
  ) dut (
    .PCLK                         (PCLK),
    .PRESET                       (PRESET),
    .from_cpu_resetn              (from_cpu_resetn),
    .from_cpu_valid_txn           (from_cpu_valid_txn),
    .from_cpu_rd_wr               (from_cpu_rd_wr),
    .from_cpu_address             (from_cpu_address),
    .from_cpu_wr_STRB             (from_cpu_wr_STRB),
    .from_cpu_wr_WDATA            (from_cpu_wr_WDATA),
    .from_cpu_slave_sel           (from_cpu_slave_sel),
    .apb_ready_for_txn            (apb_ready_for_txn),
    .to_cpu_RDATA                 (to_cpu_RDATA),
    .to_cpu_RDATA_valid_WDATA_done(to_cpu_RDATA_valid_WDATA_done),
    .to_cpu_txn_err               (to_cpu_txn_err),
    .to_cpu_txn_timeout           (to_cpu_txn_timeout),
    .PREADY                       (PREADY),
    .PRDATA                       (PRDATA),
    .PSLVERR                      (PSLVERR),
    .PADDR                        (PADDR),
    .PPROT                        (PPROT),
    .PSELx                        (PSELx),
    .PENABLE                      (PENABLE),
    .PWRITE                       (PWRITE),
    .PWDATA                       (PWDATA),
    .PSTRB                        (PSTRB)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every completion pulse must match the oldest queued expectation
  always @(negedge PCLK) begin
    if (to_cpu_RDATA_valid_WDATA_done) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_done", 1, 0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check("sb_rdata", to_cpu_RDATA, e.rdata);
        check("sb_err", to_cpu_txn_err, e.err);
        check("sb_timeout", to_cpu_txn_timeout, e.timeout);
      end
    end else begin
      check("pulse_without_done", {to_cpu_txn_err, to_cpu_txn_timeout}, 0);
    end
  end

  task automatic drive_req(input logic rd_wr, input logic [AW-1:0] addr, input logic [SW-1:0] strb,
                           input logic [DW-1:0] wdata, input logic sel);
    from_cpu_valid_txn = 1'b1;
    from_cpu_rd_wr     = rd_wr;
    from_cpu_address   = addr;
    from_cpu_wr_STRB   = strb;
    from_cpu_wr_WDATA  = wdata;
    from_cpu_slave_sel = sel;
  endtask

  task automatic run_txn(input txn_t v);
    sb_t           e;
    logic [DW-1:0] exp_pwdata;
    logic [SW-1:0] exp_pstrb;
    exp_pwdata = v.rd_wr ? v.wdata : '0;
    exp_pstrb  = v.rd_wr ? v.strb : '0;
    @(negedge PCLK);
    check("idle_ready", apb_ready_for_txn, 1);
    drive_req(v.rd_wr, v.addr, v.strb, v.wdata, v.sel);
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    e.rdata = v.exp_rdata;
    e.err = v.exp_err;
    e.timeout = 1'b0;
    sb_q.push_back(e);
    @(negedge PCLK);
    from_cpu_valid_txn = 1'b0;
    if (!v.sel) begin
      check("dec_psel", PSELx, 0);
      check("dec_done", to_cpu_RDATA_valid_WDATA_done, 1);
      @(negedge PCLK);
      check("dec_ready", apb_ready_for_txn, 1);
      check("dec_psel2", PSELx, 0);
      return;
    end
    check("setup_sel_en", {PSELx, PENABLE}, 2'b10);
    check("setup_paddr", PADDR, v.addr);
    check("setup_pwrite", PWRITE, v.rd_wr);
    check("setup_pwdata", PWDATA, exp_pwdata);
    check("setup_pstrb", PSTRB, exp_pstrb);
    check("setup_ready", apb_ready_for_txn, 0);
    for (int k = 0; k <= v.waits; k++) begin
      @(negedge PCLK);
      check("access_sel_en", {PSELx, PENABLE}, 2'b11);
      check("access_paddr", PADDR, v.addr);
      check("access_pwdata", PWDATA, exp_pwdata);
      check("access_pstrb", PSTRB, exp_pstrb);
      check("access_no_done", to_cpu_RDATA_valid_WDATA_done, 0);
      PREADY  = (k == v.waits);
      PRDATA  = v.prdata;
      PSLVERR = (k == v.waits) ? v.pslverr : 1'b0;
    end
    @(negedge PCLK);
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    check("done_pulse", to_cpu_RDATA_valid_WDATA_done, 1);
    check("done_sel_en", {PSELx, PENABLE}, 2'b00);
    @(negedge PCLK);
    check("post_ready", apb_ready_for_txn, 1);
    check("post_done", to_cpu_RDATA_valid_WDATA_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1, 0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 32'h20, 4'hF, 32'h11111111, 1'b1, 3, 32'h12345678, 1'b0, 32'h12345678, 1'b0};
    vecs[2] = '{1'b1, 32'h24, 4'h5, 32'hA5A5A5A5, 1'b1, 1, 32'hFFFFFFFF, 1'b1, 32'h12345678, 1'b1};
    vecs[3] = '{1'b0, 32'h30, 4'h0, 32'h0, 1'b0, 0, 32'h0, 1'b0, 32'h12345678, 1'b1};
    vecs[4] = '{1'b0, 32'h34, 4'h3, 32'h22222222, 1'b1, 0, 32'hAAAA5555, 1'b1, 32'h12345678, 1'b1};
    vecs[5] = '{1'b0, 32'hFFFFFFFC, 4'h0, 32'h0, 1'b1, 0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0};
    vecs[6] = '{1'b1, 32'h40, 4'h3, 32'h0000BEEF, 1'b1, 2, 32'h99999999, 1'b0, 32'hCAFEF00D, 1'b0};

    PRESET = 1'b1;
    from_cpu_resetn = 1'b1;
    from_cpu_valid_txn = 1'b0;
    from_cpu_rd_wr = 1'b0;
    from_cpu_address = '0;
    from_cpu_wr_STRB = '0;
    from_cpu_wr_WDATA = '0;
    from_cpu_slave_sel = 1'b0;
    PREADY = 1'b0;
    PRDATA = '0;
    PSLVERR = 1'b0;
    repeat (3) @(negedge PCLK);
    check("rst_ready", apb_ready_for_txn, 1);
    check("rst_sel_en_wr", {PSELx, PENABLE, PWRITE}, 3'b000);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_pstrb", PSTRB, 0);
    check("rst_rdata", to_cpu_RDATA, 0);
    check("rst_pulses", {to_cpu_RDATA_valid_WDATA_done, to_cpu_txn_err, to_cpu_txn_timeout}, 0);
    check("rst_pprot", PPROT, 3'b000);
    PRESET = 1'b0;

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // PRESET in ACCESS; a second request during SETUP must be ignored
    @(negedge PCLK);
    drive_req(1'b0, 32'h44, 4'h0, 32'h0, 1'b1);
    @(negedge PCLK);
    drive_req(1'b1, 32'h88, 4'hF, 32'h5555AAAA, 1'b1);
    check("rstmid_setup", {PSELx, PENABLE}, 2'b10);
    @(negedge PCLK);
    from_cpu_valid_txn = 1'b0;
    check("rstmid_access", {PSELx, PENABLE}, 2'b11);
    check("rstmid_ign_addr", PADDR, 32'h44);
    check("rstmid_ign_wr", PWRITE, 0);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    check("rstmid_sel_en", {PSELx, PENABLE}, 2'b00);
    check("rstmid_ready", apb_ready_for_txn, 1);
    check("rstmid_done", to_cpu_RDATA_valid_WDATA_done, 0);
    check("rstmid_rdata", to_cpu_RDATA, 0);
    @(negedge PCLK);
    check("rstmid_idle", {PSELx, apb_ready_for_txn}, 2'b01);

    // CPU soft reset during SETUP
    drive_req(1'b1, 32'h50, 4'hF, 32'h01020304, 1'b1);
    @(negedge PCLK);
    from_cpu_valid_txn = 1'b0;
    from_cpu_resetn = 1'b0;
    check("soft_setup", PSELx, 1);
    @(negedge PCLK);
    from_cpu_resetn = 1'b1;
    check("soft_sel_en", {PSELx, PENABLE}, 2'b00);
    check("soft_ready", apb_ready_for_txn, 1);
    check("soft_done", to_cpu_RDATA_valid_WDATA_done, 0);

`ifdef VIP_AMBA_APB_TIMEOUT_EN
    begin
      int   n_acc;
      logic seen;
      sb_t  e;
      @(negedge PCLK);
      drive_req(1'b0, 32'h5C, 4'h0, 32'h0, 1'b1);
      PREADY = 1'b0;
      e.rdata = 32'h0;
      e.err = 1'b1;
      e.timeout = 1'b1;
      sb_q.push_back(e);
      @(negedge PCLK);
      from_cpu_valid_txn = 1'b0;
      n_acc = 0;
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        @(negedge PCLK);
        if (to_cpu_RDATA_valid_WDATA_done) seen = 1'b1;
        else if (PENABLE) n_acc++;
      end
      check("to_seen", seen, 1);
      check("to_access_cycles", n_acc, TO);
      check("to_sel_en", {PSELx, PENABLE}, 2'b00);
      @(negedge PCLK);
      check("to_ready", apb_ready_for_txn, 1);
    end
`else
    begin
      int  n_acc;
      sb_t e;
      @(negedge PCLK);
      drive_req(1'b0, 32'h5C, 4'h0, 32'h0, 1'b1);
      PREADY = 1'b0;
      PRDATA = 32'h0BADF00D;
      e.rdata = 32'h0BADF00D;
      e.err = 1'b0;
      e.timeout = 1'b0;
      sb_q.push_back(e);
      @(negedge PCLK);
      from_cpu_valid_txn = 1'b0;
      n_acc = 0;
      for (int c = 0; c < 30; c++) begin
        @(negedge PCLK);
        if (PSELx && PENABLE && !to_cpu_RDATA_valid_WDATA_done) n_acc++;
      end
      check("nto_wait_cycles", n_acc, 30);
      PREADY = 1'b1;
      @(negedge PCLK);
      PREADY = 1'b0;
      check("nto_done", to_cpu_RDATA_valid_WDATA_done, 1);
      @(negedge PCLK);
    end
`endif

    begin
      txn_t v;
      v = '{1'b0, 32'h60, 4'hF, 32'h0, 1'b1, 1, 32'h600DCAFE, 1'b0, 32'h600DCAFE, 1'b0};
      run_txn(v);
    end

    repeat (2) @(negedge PCLK);
    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
